// File: rtl/ddr2_blk_rdwr_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_blk_rdwr_pkg
// Shared constants for the DDR2 block read/write engine width converter.
//   IN_BYTES  : bytes per upstream packet word (64-bit)
//   OUT_BYTES : bytes per DDR2 word (72-bit)
//   CNT_W     : width of the residual byte counter (holds 0..8)
// ----------------------------------------------------------------------------
package ddr2_blk_rdwr_pkg;

    localparam int unsigned IN_BYTES  = 8;
    localparam int unsigned OUT_BYTES = 9;
    localparam int unsigned CNT_W     = 4;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// ----------------------------------------------------------------------------
// fallthrough_small_fifo
// Small first-word-fall-through FIFO. The head entry is presented on dout as
// soon as the FIFO is non-empty; rd_en pops it.
//   clk, rst   : clock, synchronous active-high reset
//   din, wr_en : write port (write while prog_full is the caller's concern)
//   rd_en      : pop head (legal only when empty=0)
//   dout       : head entry, zero while empty
//   empty      : no entries held
//   prog_full  : occupancy >= PROG_FULL_THRESHOLD
// ----------------------------------------------------------------------------
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH               = 72,
    parameter int unsigned MAX_DEPTH_BITS      = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             prog_full
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int unsigned CW    = MAX_DEPTH_BITS + 1;
    localparam logic [CW-1:0] THR = CW'(PROG_FULL_THRESHOLD);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign empty     = (count_q == '0);
    assign prog_full = (count_q >= THR);
    assign dout      = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ddr2_blk_rdwr_fifo_64b_2_72b.sv
// ----------------------------------------------------------------------------
// ddr2_blk_rdwr_fifo_64b_2_72b
// Packs a big-endian stream of 64-bit words into 72-bit DDR2 words (nine in,
// eight out). flush pads and emits a partial word. Packed words pass through
// one register stage into a fall-through FIFO drained by the write sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   wr_data/wr_en : input word, byte 0 at [63:56]; only when full=0
//   flush         : one-cycle pulse, emit residual bytes zero-padded
//   full          : flush pending or output FIFO at threshold
//   rd_data       : FIFO head, byte 0 at [71:64]
//   empty         : output FIFO empty
//   rd_en         : pop FIFO head; only when empty=0
//   pending_bytes : residual byte count 0..8
// ----------------------------------------------------------------------------
module ddr2_blk_rdwr_fifo_64b_2_72b
    import ddr2_blk_rdwr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_BITS     = 3,
    parameter int unsigned PROG_FULL_THRESHOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] wr_data,
    input  logic        wr_en,
    input  logic        flush,
    output logic        full,
    output logic [71:0] rd_data,
    output logic        empty,
    input  logic        rd_en,
    output logic [3:0]  pending_bytes
);

    localparam logic [6:0] OUT_BITS = 7'(8 * OUT_BYTES);
    localparam cnt_t       R_FULL   = CNT_W'(IN_BYTES);

    logic [63:0] residual_q, residual_d;
    cnt_t        r_q, r_d;
    logic        flush_pending_q, flush_pending_d;
    logic        wr_en_d1_q, wr_en_d1_d;
    logic [71:0] data_d1_q, data_d1_d;

    logic [6:0]  sh_in;
    logic [6:0]  sh_res;
    logic        prog_full;

    always_comb begin
        residual_d      = residual_q;
        r_d             = r_q;
        flush_pending_d = flush_pending_q;
        wr_en_d1_d      = 1'b0;
        data_d1_d       = '0;
        // Residual occupies the top r bytes; the new word lands right after
        // it and whatever does not fit becomes the next residual.
        sh_in           = {r_q, 3'b000};
        sh_res          = OUT_BITS - {r_q, 3'b000};

        if (flush_pending_q || (flush && !wr_en)) begin
            flush_pending_d = 1'b0;
            if (r_q != '0) begin
                wr_en_d1_d = 1'b1;
                data_d1_d  = {residual_q, 8'h00};
            end
            residual_d = '0;
            r_d        = '0;
        end else if (wr_en) begin
            if (r_q == '0) begin
                residual_d = wr_data;
                r_d        = R_FULL;
            end else begin
                wr_en_d1_d = 1'b1;
                data_d1_d  = {residual_q, 8'h00} | ({wr_data, 8'h00} >> sh_in);
                residual_d = wr_data << sh_res;
                r_d        = r_q - 1'b1;
            end
            // Flush alongside a write runs on the following cycle.
            flush_pending_d = flush;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            residual_q      <= '0;
            r_q             <= '0;
            flush_pending_q <= 1'b0;
            wr_en_d1_q      <= 1'b0;
            data_d1_q       <= '0;
        end else begin
            residual_q      <= residual_d;
            r_q             <= r_d;
            flush_pending_q <= flush_pending_d;
            wr_en_d1_q      <= wr_en_d1_d;
            data_d1_q       <= data_d1_d;
        end
    end

    fallthrough_small_fifo #(
        .WIDTH               (72),
        .MAX_DEPTH_BITS      (FIFO_DEPTH_BITS),
        .PROG_FULL_THRESHOLD (PROG_FULL_THRESHOLD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .din       (data_d1_q),
        .wr_en     (wr_en_d1_q),
        .rd_en     (rd_en),
        .dout      (rd_data),
        .empty     (empty),
        .prog_full (prog_full)
    );

    assign full          = flush_pending_q | prog_full;
    assign pending_bytes = r_q;

endmodule

// File: tb/tb_ddr2_blk_rdwr_fifo_64b_2_72b.sv
module tb_ddr2_blk_rdwr_fifo_64b_2_72b;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] wr_data;
    logic        wr_en;
    logic        flush;
    logic        full;
    logic [71:0] rd_data;
    logic        empty;
    logic        rd_en;
    logic [3:0]  pending_bytes;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        s_full;
    logic        s_empty;
    logic [3:0]  s_pend;
    bit          auto_rd;
    logic [71:0] got[$];
    int          stamp[$];

    ddr2_blk_rdwr_fifo_64b_2_72b #(
        .FIFO_DEPTH_BITS     (3),
        .PROG_FULL_THRESHOLD (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .flush         (flush),
        .full          (full),
        .rd_data       (rd_data),
        .empty         (empty),
        .rd_en         (rd_en),
        .pending_bytes (pending_bytes)
    );

    always #5 clk = ~clk;

    // Input word i carries stream bytes 8i..8i+7.
    function automatic logic [63:0] in_word(input int i);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[55:0], 8'(8 * i + j)};
        return w;
    endfunction

    // Output word k carries stream bytes 9k..9k+8.
    function automatic logic [71:0] exp_word(input int k);
        logic [71:0] w;
        w = '0;
        for (int j = 0; j < 9; j++) w = {w[63:0], 8'(9 * k + j)};
        return w;
    endfunction

    function automatic logic [71:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 'x;
    endfunction

    function automatic int stamp_at(input int i);
        if (i < stamp.size()) return stamp[i];
        return -1000;
    endfunction

    task automatic chk72(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One negedge: sample outputs, optionally pop the head.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_full  = full;
        s_empty = empty;
        s_pend  = pending_bytes;
        if (auto_rd && !empty) begin
            got.push_back(rd_data);
            stamp.push_back(cyc);
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [63:0] d, input logic fl);
        wr_en   = we;
        wr_data = d;
        flush   = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            drive(1'b0, '0, 1'b0);
        end
    endtask

    task automatic clear_out();
        got.delete();
        stamp.delete();
    endtask

    task automatic run_full_group(input string tag);
        int c_w1;
        clear_out();
        auto_rd = 1'b1;
        c_w1 = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 1) c_w1 = cyc;
            drive(1'b1, in_word(i), 1'b0);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        chk_int({tag, "_pend_end"}, int'(s_pend), 0);
        idle(8);
        chk_int({tag, "_count"}, got.size(), 8);
        for (int k = 0; k < 8; k++) chk72($sformatf("%s_out%0d", tag, k), got_at(k), exp_word(k));
        chk_int({tag, "_latency"}, stamp_at(0) - c_w1, 2);
    endtask

    initial begin
        int f3, f4, n, guard;
        bit seen;

        rst = 1'b1;
        rd_en = 1'b0;
        auto_rd = 1'b0;
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        chk_int("rst_empty", int'(s_empty), 1);
        chk_int("rst_full", int'(s_full), 0);
        chk_int("rst_pend", int'(s_pend), 0);
        chk72("rst_rd_data", rd_data, 72'h0);
        rst = 1'b0;

        // Case 1: one full group of nine words.
        run_full_group("grp");

        // Case 2: flush after a single word.
        clear_out();
        tick();
        drive(1'b1, 64'h0001020304050607, 1'b0);
        tick();
        chk_int("fl1_pend8", int'(s_pend), 8);
        drive(1'b0, '0, 1'b1);
        tick();
        chk_int("fl1_pend0", int'(s_pend), 0);
        drive(1'b0, '0, 1'b0);
        idle(8);
        chk_int("fl1_count", got.size(), 1);
        chk72("fl1_out0", got_at(0), 72'h000102030405060700);

        // Case 3: two words then a separate flush.
        clear_out();
        tick();
        drive(1'b1, 64'h0001020304050607, 1'b0);
        tick();
        drive(1'b1, 64'h08090A0B0C0D0E0F, 1'b0);
        tick();
        f3 = cyc;
        drive(1'b0, '0, 1'b1);
        idle(8);
        chk_int("fl2_count", got.size(), 2);
        chk72("fl2_out0", got_at(0), 72'h000102030405060708);
        chk72("fl2_out1", got_at(1), 72'h090A0B0C0D0E0F0000);
        chk_int("fl2_lat", stamp_at(1) - f3, 2);

        // Case 4: flush together with the second write.
        clear_out();
        tick();
        drive(1'b1, 64'h0001020304050607, 1'b0);
        tick();
        f4 = cyc;
        chk_int("flw_full_before", int'(s_full), 0);
        drive(1'b1, 64'h08090A0B0C0D0E0F, 1'b1);
        tick();
        chk_int("flw_full_hi", int'(s_full), 1);
        drive(1'b0, '0, 1'b0);
        tick();
        chk_int("flw_full_lo", int'(s_full), 0);
        drive(1'b0, '0, 1'b0);
        idle(8);
        chk_int("flw_count", got.size(), 2);
        chk72("flw_out0", got_at(0), 72'h000102030405060708);
        chk72("flw_out1", got_at(1), 72'h090A0B0C0D0E0F0000);
        chk_int("flw_lat", stamp_at(1) - f4, 3);

        // Case 5: backpressure, 27 words, reads start once full is seen.
        clear_out();
        auto_rd = 1'b0;
        n = 0;
        seen = 1'b0;
        guard = 0;
        while (got.size() < 24 && guard < 600) begin
            guard++;
            tick();
            if (!seen && s_full) begin
                seen = 1'b1;
                chk_int("bp_words_at_full", n, 6);
                auto_rd = 1'b1;
            end
            if (!s_full && n < 27) begin
                drive(1'b1, in_word(n), 1'b0);
                n++;
            end else begin
                drive(1'b0, '0, 1'b0);
            end
        end
        idle(8);
        chk_int("bp_full_seen", int'(seen), 1);
        chk_int("bp_words_in", n, 27);
        chk_int("bp_count", got.size(), 24);
        for (int k = 0; k < 24; k++) chk72($sformatf("bp_out%0d", k), got_at(k), exp_word(k));
        chk_int("bp_pend", int'(s_pend), 0);
        chk_int("bp_empty", int'(s_empty), 1);

        // Case 6: reset in the middle of a block, then a clean group.
        clear_out();
        auto_rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(1'b1, in_word(i + 20), 1'b0);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_int("mid_rst_empty", int'(s_empty), 1);
        chk_int("mid_rst_full", int'(s_full), 0);
        chk_int("mid_rst_pend", int'(s_pend), 0);
        idle(3);
        chk_int("mid_rst_still_empty", int'(s_empty), 1);
        run_full_group("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
